// File: rtl/narrower_fifo.sv
// Single-clock width-down FIFO: wide words in, narrow slices out (LS slice first),
// with show-ahead read data and registered flags/counts derived from next-state pointers.
module narrower_fifo #(
  parameter int DEPTH_LG2    = 4,
  parameter int WRDATA_WIDTH = 32,
  parameter int RDDATA_WIDTH = 16,
  parameter bit RST_MEM      = 1'b0
) (
  input  logic                                                                   clk,
  input  logic                                                                   rst_n,
  input  logic                                                                   wrreq,
  input  logic [WRDATA_WIDTH-1:0]                                                wdata_i,
  output logic                                                                   wrfull_o,
  output logic [DEPTH_LG2:0]                                                     wrusedw_o,
  input  logic                                                                   rdreq,
  output logic [RDDATA_WIDTH-1:0]                                                rdata_o,
  output logic                                                                   rdempty_o,
  output logic [DEPTH_LG2+$clog2(WRDATA_WIDTH/RDDATA_WIDTH):0]                   rdusedw_o,
  output logic                                                                   overflow_o,
  output logic                                                                   underflow_o
);

  localparam int WIDTH_RATIO = WRDATA_WIDTH / RDDATA_WIDTH;
  localparam int RATIO_LG2   = $clog2(WIDTH_RATIO);
  localparam int FIFO_DEPTH  = 2 ** DEPTH_LG2;
  localparam int WPTR_W      = DEPTH_LG2 + 1;
  localparam int RPTR_W      = DEPTH_LG2 + RATIO_LG2 + 1;

  localparam logic [WPTR_W-1:0] WPTR_ONE   = WPTR_W'(1);
  localparam logic [RPTR_W-1:0] RPTR_ONE   = RPTR_W'(1);
  localparam logic [WPTR_W-1:0] FULL_COUNT = WPTR_W'(FIFO_DEPTH);

  logic [WRDATA_WIDTH-1:0] mem_q [FIFO_DEPTH];

  logic [WPTR_W-1:0] wrptr_q, wrptr_d;
  logic [RPTR_W-1:0] rdptr_q, rdptr_d;
  logic [WPTR_W-1:0] rdwptr_d;
  logic [WPTR_W-1:0] wrusedw_q, wrusedw_d;
  logic [RPTR_W-1:0] rdusedw_q, rdusedw_d;
  logic              wrfull_q, wrfull_d;
  logic              rdempty_q, rdempty_d;
  logic              overflow_q, overflow_d;
  logic              underflow_q, underflow_d;
  logic              wr_accept, rd_accept;

  logic [WIDTH_RATIO-1:0][RDDATA_WIDTH-1:0] head_slices;

  // Accept decisions use the registered flags, so a write at full is rejected even
  // when the same edge frees the head entry.
  always_comb begin
    wr_accept   = wrreq & ~wrfull_q;
    rd_accept   = rdreq & ~rdempty_q;
    overflow_d  = wrreq & wrfull_q;
    underflow_d = rdreq & rdempty_q;

    wrptr_d = wrptr_q;
    if (wr_accept) begin
      wrptr_d = wrptr_q + WPTR_ONE;
    end
    rdptr_d = rdptr_q;
    if (rd_accept) begin
      rdptr_d = rdptr_q + RPTR_ONE;
    end

    rdwptr_d  = rdptr_d[RPTR_W-1:RATIO_LG2];
    wrusedw_d = wrptr_d - rdwptr_d;
    rdusedw_d = {wrptr_d, {RATIO_LG2{1'b0}}} - rdptr_d;
    wrfull_d  = (wrusedw_d == FULL_COUNT);
    rdempty_d = (rdusedw_d == '0);
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wrptr_q     <= '0;
      rdptr_q     <= '0;
      wrusedw_q   <= '0;
      rdusedw_q   <= '0;
      wrfull_q    <= 1'b0;
      rdempty_q   <= 1'b1;
      overflow_q  <= 1'b0;
      underflow_q <= 1'b0;
    end else begin
      wrptr_q     <= wrptr_d;
      rdptr_q     <= rdptr_d;
      wrusedw_q   <= wrusedw_d;
      rdusedw_q   <= rdusedw_d;
      wrfull_q    <= wrfull_d;
      rdempty_q   <= rdempty_d;
      overflow_q  <= overflow_d;
      underflow_q <= underflow_d;
    end
  end

  generate
    if (RST_MEM) begin : g_mem_rst
      always_ff @(posedge clk) begin
        if (!rst_n) begin
          for (int i = 0; i < FIFO_DEPTH; i++) begin
            mem_q[i] <= '0;
          end
        end else if (wr_accept) begin
          mem_q[wrptr_q[DEPTH_LG2-1:0]] <= wdata_i;
        end
      end
    end else begin : g_mem_norst
      always_ff @(posedge clk) begin
        if (rst_n && wr_accept) begin
          mem_q[wrptr_q[DEPTH_LG2-1:0]] <= wdata_i;
        end
      end
    end
  endgenerate

  // Show-ahead: the low read-pointer bits pick the slice within the head word.
  assign head_slices = mem_q[rdptr_q[RPTR_W-2:RATIO_LG2]];
  assign rdata_o     = head_slices[rdptr_q[RATIO_LG2-1:0]];

  assign wrfull_o    = wrfull_q;
  assign rdempty_o   = rdempty_q;
  assign wrusedw_o   = wrusedw_q;
  assign rdusedw_o   = rdusedw_q;
  assign overflow_o  = overflow_q;
  assign underflow_o = underflow_q;

`ifdef NARROWER_FIFO_SIM_CHECKS
  // Opt-in protocol checks; off by default so error-path exercising stays quiet.
  always @(posedge clk) begin
    if (rst_n && wrreq && wrfull_q) $error("narrower_fifo: write while full");
    if (rst_n && rdreq && rdempty_q) $error("narrower_fifo: read while empty");
  end
`endif

endmodule

// File: tb/tb_narrower_fifo.sv
// Self-checking bench for narrower_fifo: directed scenarios plus randomized traffic,
// all compared against a word-queue reference model.
module tb_narrower_fifo;

  localparam int DEPTH = 16;
  localparam int RATIO = 2;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        wrreq = 1'b0;
  logic [31:0] wdata_i = '0;
  logic        wrfull_o;
  logic [4:0]  wrusedw_o;
  logic        rdreq = 1'b0;
  logic [15:0] rdata_o;
  logic        rdempty_o;
  logic [5:0]  rdusedw_o;
  logic        overflow_o;
  logic        underflow_o;

  int n_checks = 0;
  int n_fail   = 0;

  // Reference model: stored wide words plus how many slices of the head are consumed.
  logic [31:0] wq[$];
  int          head = 0;
  bit          exp_ovf = 1'b0;
  bit          exp_unf = 1'b0;

  narrower_fifo #(
    .DEPTH_LG2(4), .WRDATA_WIDTH(32), .RDDATA_WIDTH(16), .RST_MEM(1'b0)
  ) dut (
    .clk(clk), .rst_n(rst_n),
    .wrreq(wrreq), .wdata_i(wdata_i), .wrfull_o(wrfull_o), .wrusedw_o(wrusedw_o),
    .rdreq(rdreq), .rdata_o(rdata_o), .rdempty_o(rdempty_o), .rdusedw_o(rdusedw_o),
    .overflow_o(overflow_o), .underflow_o(underflow_o)
  );

  always #5 clk = ~clk;

  function automatic int m_slices();
    return wq.size() * RATIO - head;
  endfunction

  function automatic logic [15:0] m_head();
    logic [31:0] w;
    if (wq.size() == 0) return 16'h0;
    w = wq[0];
    return w[head*16 +: 16];
  endfunction

  // Drives one cycle (called just after a falling edge) and advances the model.
  task automatic drive(input bit wr, input logic [31:0] wd, input bit rd);
    bit wr_ok, rd_ok;
    wrreq   = wr;
    wdata_i = wd;
    rdreq   = rd;
    exp_ovf = wr && (wq.size() == DEPTH);
    exp_unf = rd && (m_slices() == 0);
    wr_ok   = wr && !exp_ovf;
    rd_ok   = rd && !exp_unf;
    @(posedge clk);
    if (rd_ok) begin
      head++;
      if (head == RATIO) begin
        void'(wq.pop_front());
        head = 0;
      end
    end
    if (wr_ok) wq.push_back(wd);
    #1;
    wrreq = 1'b0;
    rdreq = 1'b0;
    @(negedge clk);
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    wrreq = 1'b0;
    rdreq = 1'b0;
    @(posedge clk);
    #1 rst_n = 1'b1;
    wq.delete();
    head = 0;
    @(negedge clk);
  endtask

  task automatic test_reset();
    $display("[TB] test_reset");
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    wq.delete();
    head = 0;
    @(negedge clk);
    n_checks++; if (rdempty_o !== 1'b1) begin n_fail++; $display("[TB] FAIL reset_rdempty: got %0b expected 1", rdempty_o); end
    n_checks++; if (wrfull_o !== 1'b0) begin n_fail++; $display("[TB] FAIL reset_wrfull: got %0b expected 0", wrfull_o); end
    n_checks++; if (wrusedw_o !== 5'd0) begin n_fail++; $display("[TB] FAIL reset_wrusedw: got %0d expected 0", wrusedw_o); end
    n_checks++; if (rdusedw_o !== 6'd0) begin n_fail++; $display("[TB] FAIL reset_rdusedw: got %0d expected 0", rdusedw_o); end
    n_checks++; if (overflow_o !== 1'b0 || underflow_o !== 1'b0) begin n_fail++; $display("[TB] FAIL reset_errflags: got %0b%0b expected 00", overflow_o, underflow_o); end
  endtask

  task automatic test_slice_order();
    $display("[TB] test_slice_order");
    do_reset();
    drive(1'b1, 32'h1234_5678, 1'b0);
    n_checks++; if (rdempty_o !== 1'b0) begin n_fail++; $display("[TB] FAIL order_notempty: got %0b expected 0", rdempty_o); end
    n_checks++; if (rdusedw_o !== 6'd2) begin n_fail++; $display("[TB] FAIL order_rdusedw2: got %0d expected 2", rdusedw_o); end
    n_checks++; if (rdata_o !== 16'h5678) begin n_fail++; $display("[TB] FAIL order_slice0: got %h expected 5678", rdata_o); end
    drive(1'b0, '0, 1'b1);
    n_checks++; if (rdata_o !== 16'h1234) begin n_fail++; $display("[TB] FAIL order_slice1: got %h expected 1234", rdata_o); end
    n_checks++; if (rdusedw_o !== 6'd1) begin n_fail++; $display("[TB] FAIL order_rdusedw1: got %0d expected 1", rdusedw_o); end
    drive(1'b0, '0, 1'b1);
    n_checks++; if (rdusedw_o !== 6'd0) begin n_fail++; $display("[TB] FAIL order_rdusedw0: got %0d expected 0", rdusedw_o); end
    n_checks++; if (rdempty_o !== 1'b1) begin n_fail++; $display("[TB] FAIL order_empty: got %0b expected 1", rdempty_o); end
  endtask

  task automatic test_fill_overflow();
    logic [31:0] words [DEPTH];
    logic [31:0] w;
    logic [15:0] e;
    $display("[TB] test_fill_overflow");
    do_reset();
    for (int i = 0; i < DEPTH; i++) begin
      words[i] = $urandom;
      drive(1'b1, words[i], 1'b0);
    end
    n_checks++; if (wrusedw_o !== 5'd16) begin n_fail++; $display("[TB] FAIL fill_wrusedw: got %0d expected 16", wrusedw_o); end
    n_checks++; if (wrfull_o !== 1'b1) begin n_fail++; $display("[TB] FAIL fill_wrfull: got %0b expected 1", wrfull_o); end
    n_checks++; if (rdusedw_o !== 6'd32) begin n_fail++; $display("[TB] FAIL fill_rdusedw: got %0d expected 32", rdusedw_o); end
    drive(1'b1, 32'hFFFF_FFFF, 1'b0);
    n_checks++; if (overflow_o !== 1'b1) begin n_fail++; $display("[TB] FAIL ovf_pulse: got %0b expected 1", overflow_o); end
    n_checks++; if (wrusedw_o !== 5'd16) begin n_fail++; $display("[TB] FAIL ovf_wrusedw: got %0d expected 16", wrusedw_o); end
    drive(1'b0, '0, 1'b0);
    n_checks++; if (overflow_o !== 1'b0) begin n_fail++; $display("[TB] FAIL ovf_once: got %0b expected 0", overflow_o); end
    for (int k = 0; k < DEPTH * RATIO; k++) begin
      w = words[k/2];
      e = (k % 2) ? w[31:16] : w[15:0];
      n_checks++; if (rdata_o !== e) begin n_fail++; $display("[TB] FAIL drain_slice%0d: got %h expected %h", k, rdata_o, e); end
      drive(1'b0, '0, 1'b1);
    end
    n_checks++; if (rdempty_o !== 1'b1) begin n_fail++; $display("[TB] FAIL drain_empty: got %0b expected 1", rdempty_o); end
  endtask

  task automatic test_partial_free();
    $display("[TB] test_partial_free");
    do_reset();
    for (int i = 0; i < DEPTH; i++) drive(1'b1, $urandom, 1'b0);
    drive(1'b0, '0, 1'b1);
    n_checks++; if (wrfull_o !== 1'b1) begin n_fail++; $display("[TB] FAIL pf_full_held: got %0b expected 1", wrfull_o); end
    n_checks++; if (wrusedw_o !== 5'd16) begin n_fail++; $display("[TB] FAIL pf_wrusedw16: got %0d expected 16", wrusedw_o); end
    n_checks++; if (rdusedw_o !== 6'd31) begin n_fail++; $display("[TB] FAIL pf_rdusedw31: got %0d expected 31", rdusedw_o); end
    // Last-slice read and write together while full: read wins, write is rejected.
    drive(1'b1, 32'hCAFE_F00D, 1'b1);
    n_checks++; if (overflow_o !== 1'b1) begin n_fail++; $display("[TB] FAIL pf_concurrent_ovf: got %0b expected 1", overflow_o); end
    n_checks++; if (wrfull_o !== 1'b0) begin n_fail++; $display("[TB] FAIL pf_full_clear: got %0b expected 0", wrfull_o); end
    n_checks++; if (wrusedw_o !== 5'd15) begin n_fail++; $display("[TB] FAIL pf_wrusedw15: got %0d expected 15", wrusedw_o); end
    n_checks++; if (rdusedw_o !== 6'd30) begin n_fail++; $display("[TB] FAIL pf_rdusedw30: got %0d expected 30", rdusedw_o); end
    drive(1'b1, 32'h0BAD_0BAD, 1'b0);
    n_checks++; if (wrfull_o !== 1'b1 || overflow_o !== 1'b0) begin n_fail++; $display("[TB] FAIL pf_refill: got full=%0b ovf=%0b expected full=1 ovf=0", wrfull_o, overflow_o); end
    n_checks++; if (rdata_o !== m_head()) begin n_fail++; $display("[TB] FAIL pf_head: got %h expected %h", rdata_o, m_head()); end
  endtask

  task automatic test_concurrent();
    logic [15:0] stream[$];
    logic [15:0] e;
    int          k;
    $display("[TB] test_concurrent");
    do_reset();
    k = 0;
    drive(1'b1, {16'(2*k+1), 16'(2*k)}, 1'b0);
    stream.push_back(16'(2*k)); stream.push_back(16'(2*k+1));
    k++;
    // Writes every other cycle to match the 2:1 slice rate of the continuous reads.
    for (int i = 0; i < 64; i++) begin
      e = stream.pop_front();
      n_checks++; if (rdata_o !== e) begin n_fail++; $display("[TB] FAIL conc_data%0d: got %h expected %h", i, rdata_o, e); end
      if (i % 2 == 0) begin
        drive(1'b1, {16'(2*k+1), 16'(2*k)}, 1'b1);
        stream.push_back(16'(2*k)); stream.push_back(16'(2*k+1));
        k++;
      end else begin
        drive(1'b0, '0, 1'b1);
      end
      n_checks++; if (overflow_o !== 1'b0 || underflow_o !== 1'b0) begin n_fail++; $display("[TB] FAIL conc_err%0d: got ovf=%0b unf=%0b expected 0 0", i, overflow_o, underflow_o); end
      n_checks++; if (wrusedw_o < 5'd1 || wrusedw_o > 5'd2) begin n_fail++; $display("[TB] FAIL conc_wrusedw%0d: got %0d expected 1..2", i, wrusedw_o); end
    end
  endtask

  task automatic test_underflow();
    $display("[TB] test_underflow");
    do_reset();
    drive(1'b0, '0, 1'b1);
    n_checks++; if (underflow_o !== 1'b1) begin n_fail++; $display("[TB] FAIL unf_pulse: got %0b expected 1", underflow_o); end
    n_checks++; if (rdusedw_o !== 6'd0 || rdempty_o !== 1'b1) begin n_fail++; $display("[TB] FAIL unf_state: got rdusedw=%0d empty=%0b expected 0 1", rdusedw_o, rdempty_o); end
    drive(1'b0, '0, 1'b0);
    n_checks++; if (underflow_o !== 1'b0) begin n_fail++; $display("[TB] FAIL unf_once: got %0b expected 0", underflow_o); end
    drive(1'b1, 32'hAAAA_5555, 1'b0);
    n_checks++; if (rdata_o !== 16'h5555) begin n_fail++; $display("[TB] FAIL unf_first: got %h expected 5555", rdata_o); end
    drive(1'b0, '0, 1'b1);
    n_checks++; if (rdata_o !== 16'hAAAA) begin n_fail++; $display("[TB] FAIL unf_second: got %h expected aaaa", rdata_o); end
  endtask

  task automatic test_mid_reset();
    $display("[TB] test_mid_reset");
    do_reset();
    for (int i = 0; i < 3; i++) drive(1'b1, $urandom, 1'b0);
    drive(1'b0, '0, 1'b1);
    do_reset();
    n_checks++; if (rdempty_o !== 1'b1 || wrfull_o !== 1'b0) begin n_fail++; $display("[TB] FAIL mid_flags: got empty=%0b full=%0b expected 1 0", rdempty_o, wrfull_o); end
    n_checks++; if (wrusedw_o !== 5'd0 || rdusedw_o !== 6'd0) begin n_fail++; $display("[TB] FAIL mid_counts: got %0d %0d expected 0 0", wrusedw_o, rdusedw_o); end
    drive(1'b1, 32'hDEAD_BEEF, 1'b0);
    n_checks++; if (rdata_o !== 16'hBEEF) begin n_fail++; $display("[TB] FAIL mid_lo: got %h expected beef", rdata_o); end
    drive(1'b0, '0, 1'b1);
    n_checks++; if (rdata_o !== 16'hDEAD) begin n_fail++; $display("[TB] FAIL mid_hi: got %h expected dead", rdata_o); end
  endtask

  task automatic test_random();
    int          pw, pr;
    bit          wr, rd;
    logic [4:0]  e_wu;
    logic [5:0]  e_ru;
    $display("[TB] test_random");
    do_reset();
    for (int c = 0; c < 400; c++) begin
      pw = ((c / 100) % 2 == 0) ? 85 : 25;
      pr = ((c / 100) % 2 == 0) ? 30 : 90;
      wr = ($urandom_range(0, 99) < pw);
      rd = ($urandom_range(0, 99) < pr);
      if (m_slices() != 0) begin
        n_checks++; if (rdata_o !== m_head()) begin n_fail++; $display("[TB] FAIL rnd_data%0d: got %h expected %h", c, rdata_o, m_head()); end
      end
      drive(wr, $urandom, rd);
      e_wu = 5'(wq.size());
      e_ru = 6'(m_slices());
      n_checks++; if (wrusedw_o !== e_wu) begin n_fail++; $display("[TB] FAIL rnd_wrusedw%0d: got %0d expected %0d", c, wrusedw_o, e_wu); end
      n_checks++; if (rdusedw_o !== e_ru) begin n_fail++; $display("[TB] FAIL rnd_rdusedw%0d: got %0d expected %0d", c, rdusedw_o, e_ru); end
      n_checks++; if (wrfull_o !== (wq.size() == DEPTH)) begin n_fail++; $display("[TB] FAIL rnd_full%0d: got %0b expected %0b", c, wrfull_o, (wq.size() == DEPTH)); end
      n_checks++; if (rdempty_o !== (e_ru == 0)) begin n_fail++; $display("[TB] FAIL rnd_empty%0d: got %0b expected %0b", c, rdempty_o, (e_ru == 0)); end
      n_checks++; if (overflow_o !== exp_ovf || underflow_o !== exp_unf) begin n_fail++; $display("[TB] FAIL rnd_err%0d: got %0b%0b expected %0b%0b", c, overflow_o, underflow_o, exp_ovf, exp_unf); end
    end
  endtask

  initial begin
    test_reset();
    test_slice_order();
    test_fill_overflow();
    test_partial_free();
    test_concurrent();
    test_underflow();
    test_mid_reset();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
